// File: rtl/secure_key_store_pkg.sv
// Shared types and the reset-time key table for secure_key_store.
// Entries beyond the table depth reset to zero and unlocked.
package secure_key_store_pkg;

  localparam int KEY_W = 256;
  localparam int KEY_N = 16;

  typedef enum logic [1:0] {
    ZS_IDLE  = 2'd0,
    ZS_SWEEP = 2'd1,
    ZS_DONE  = 2'd2
  } zstate_e;

  localparam logic [KEY_W-1:0] KEY_INIT [KEY_N] = '{
    '0, '0, {8{32'hC0DE_0002}}, '0,
    '0, '0, '0, '0,
    '0, {8{32'h5EC9_0009}}, '0, '0,
    '0, '0, '0, '0
  };

  localparam logic [KEY_N-1:0] KEY_PRELOAD   = 16'h0204;
  localparam logic [KEY_N-1:0] KEY_LOCK_INIT = 16'h0204;

  function automatic logic [KEY_W-1:0] key_word(input int i);
    if (i < KEY_N && KEY_PRELOAD[i]) return KEY_INIT[i];
    return '0;
  endfunction

  function automatic logic key_lock(input int i);
    if (i < KEY_N) return KEY_LOCK_INIT[i];
    return 1'b0;
  endfunction

endpackage

// File: rtl/secure_key_store_if.sv
// Request/response bundle between the security controller and secure_key_store.
// SECURE_KEY_STORE_PARITY_EN adds the parity inject/report signals.
interface secure_key_store_if #(
  parameter int WIDTH = 256,
  parameter int AW    = 4
);
  logic             rd_en;
  logic             wr_en;
  logic             lock_en;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wrData;
  logic             zeroize_req;
  logic [WIDTH-1:0] rdData;
  logic             rdData_valid;
  logic             access_err;
  logic             zeroize_busy;
  logic             zeroize_done;
`ifdef SECURE_KEY_STORE_PARITY_EN
  logic             inj_parity_err;
  logic             rd_parity_err;

  modport master (
    output rd_en, wr_en, lock_en, addr, wrData, zeroize_req, inj_parity_err,
    input  rdData, rdData_valid, access_err, zeroize_busy, zeroize_done, rd_parity_err
  );
  modport slave (
    input  rd_en, wr_en, lock_en, addr, wrData, zeroize_req, inj_parity_err,
    output rdData, rdData_valid, access_err, zeroize_busy, zeroize_done, rd_parity_err
  );
`else
  modport master (
    output rd_en, wr_en, lock_en, addr, wrData, zeroize_req,
    input  rdData, rdData_valid, access_err, zeroize_busy, zeroize_done
  );
  modport slave (
    input  rd_en, wr_en, lock_en, addr, wrData, zeroize_req,
    output rdData, rdData_valid, access_err, zeroize_busy, zeroize_done
  );
`endif
endinterface

// File: rtl/secure_key_store_zeroize_fsm.sv
// Zeroize sequencer: walks idx 0..LENGTH-1 one entry per cycle, then pulses done.
//   state    | meaning
//   ZS_IDLE  | waiting for start; normal accesses allowed
//   ZS_SWEEP | clearing entry idx this cycle (busy)
//   ZS_DONE  | one-cycle completion pulse
module secure_key_store_zeroize_fsm
  import secure_key_store_pkg::*;
#(
  parameter  int LENGTH = 16,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          clr,
  output logic [AW-1:0] idx
);

  zstate_e       state, state_next;
  logic [AW-1:0] idx_q, idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ZS_IDLE;
      idx_q <= '0;
    end else begin
      state <= state_next;
      idx_q <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    case (state)
      ZS_IDLE: begin
        if (start) begin
          state_next = ZS_SWEEP;
          idx_next   = '0;
        end
      end
      ZS_SWEEP: begin
        if (idx_q == AW'(LENGTH - 1)) begin
          state_next = ZS_DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx_q + AW'(1);
        end
      end
      ZS_DONE:  state_next = ZS_IDLE;
      default:  state_next = ZS_IDLE;
    endcase
  end

  assign busy = (state == ZS_SWEEP);
  assign done = (state == ZS_DONE);
  assign clr  = busy;
  assign idx  = idx_q;

endmodule

// File: rtl/secure_key_store.sv
// Key RAM with reset preload, sticky per-entry write-lock, access-violation pulse and zeroize.
// Optional SECURE_KEY_STORE_PARITY_EN adds one even-parity bit per entry.
module secure_key_store
  import secure_key_store_pkg::*;
#(
  parameter  int WIDTH  = 256,
  parameter  int LENGTH = 16,
  localparam int AW     = $clog2(LENGTH)
) (
  input logic               clk,
  input logic               rst,
  secure_key_store_if.slave bus
);

  logic [WIDTH-1:0]  ram [LENGTH];
  logic [LENGTH-1:0] lock;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              err;

  logic          z_busy, z_done, z_clr;
  logic [AW-1:0] z_idx;

  secure_key_store_zeroize_fsm #(.LENGTH(LENGTH)) u_zfsm (
    .clk   (clk),
    .rst   (rst),
    .start (bus.zeroize_req),
    .busy  (z_busy),
    .done  (z_done),
    .clr   (z_clr),
    .idx   (z_idx)
  );

  logic any_req, addr_ok, accept, wr_ok, err_next;

  // zeroize_req in IDLE takes priority: same-cycle requests are rejected
  assign any_req  = bus.rd_en | bus.wr_en | bus.lock_en;
  assign addr_ok  = 32'(bus.addr) < LENGTH;
  assign accept   = !z_busy && !z_done && !bus.zeroize_req && addr_ok;
  assign wr_ok    = bus.wr_en && accept && !lock[bus.addr];
  assign err_next = (any_req && !accept) || (bus.wr_en && accept && lock[bus.addr]);

`ifdef SECURE_KEY_STORE_PARITY_EN
  logic [LENGTH-1:0] par;
  logic              par_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) begin
        ram[i]  <= WIDTH'(key_word(i));
        lock[i] <= key_lock(i);
`ifdef SECURE_KEY_STORE_PARITY_EN
        par[i]  <= ^(WIDTH'(key_word(i)));
`endif
      end
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
`ifdef SECURE_KEY_STORE_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= err_next;
`ifdef SECURE_KEY_STORE_PARITY_EN
      par_err  <= 1'b0;
`endif
      if (bus.rd_en && accept) begin
        rd_data  <= ram[bus.addr];
        rd_valid <= 1'b1;
`ifdef SECURE_KEY_STORE_PARITY_EN
        par_err  <= (^ram[bus.addr]) != par[bus.addr];
`endif
      end
      if (wr_ok) begin
        ram[bus.addr] <= bus.wrData;
`ifdef SECURE_KEY_STORE_PARITY_EN
        par[bus.addr] <= (^bus.wrData) ^ bus.inj_parity_err;
`endif
      end
      if (bus.lock_en && accept) lock[bus.addr] <= 1'b1;
      if (z_clr && !lock[z_idx]) begin
        ram[z_idx] <= '0;
`ifdef SECURE_KEY_STORE_PARITY_EN
        par[z_idx] <= 1'b0;
`endif
      end
    end
  end

  assign bus.rdData       = rd_data;
  assign bus.rdData_valid = rd_valid;
  assign bus.access_err   = err;
  assign bus.zeroize_busy = z_busy;
  assign bus.zeroize_done = z_done;
`ifdef SECURE_KEY_STORE_PARITY_EN
  assign bus.rd_parity_err = par_err;
`endif

endmodule
